// File: rtl/baccarat_deal_fsm.sv
// Baccarat dealing sequencer: strobes card loads in deal order, applies the
// natural / player-draw / banker-draw rules, and lights the result lamps.
module baccarat_deal_fsm (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       done
);

  typedef enum logic [3:0] {
    DEAL_P1    = 4'd0,
    DEAL_D1    = 4'd1,
    DEAL_P2    = 4'd2,
    DEAL_D2    = 4'd3,
    CHECK_NAT  = 4'd4,
    DEAL_P3    = 4'd5,
    CHECK_BANK = 4'd6,
    DEAL_D3    = 4'd7,
    DONE       = 4'd8
  } state_t;

  state_t state, state_nxt;

  // Face cards, tens and out-of-range ranks all count as zero for the banker rule.
  function automatic logic [3:0] card_val(input logic [3:0] rank);
    if (rank >= 4'd1 && rank <= 4'd9) return rank;
    else return 4'd0;
  endfunction

  function automatic logic banker_draw(input logic [3:0] ds, input logic [3:0] v);
    case (ds)
      4'd0, 4'd1, 4'd2: return 1'b1;
      4'd3:             return (v != 4'd8);
      4'd4:             return (v >= 4'd2 && v <= 4'd7);
      4'd5:             return (v >= 4'd4 && v <= 4'd7);
      4'd6:             return (v >= 4'd6 && v <= 4'd7);
      default:          return 1'b0;
    endcase
  endfunction

  logic natural;
  assign natural = (pscore == 4'd8) || (pscore == 4'd9) ||
                   (dscore == 4'd8) || (dscore == 4'd9);

  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) state <= DEAL_P1;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = DEAL_P1;
    case (state)
      DEAL_P1:   state_nxt = DEAL_D1;
      DEAL_D1:   state_nxt = DEAL_P2;
      DEAL_P2:   state_nxt = DEAL_D2;
      DEAL_D2:   state_nxt = CHECK_NAT;
      CHECK_NAT: begin
        if (natural)                                state_nxt = DONE;
        else if (pscore <= 4'd5)                    state_nxt = DEAL_P3;
        else if (pscore <= 4'd7 && dscore <= 4'd5)  state_nxt = DEAL_D3;
        else                                        state_nxt = DONE;
      end
      // Extra state lets pcard3 and the updated scores settle before the banker decides.
      DEAL_P3:    state_nxt = CHECK_BANK;
      CHECK_BANK: state_nxt = banker_draw(dscore, card_val(pcard3)) ? DEAL_D3 : DONE;
      DEAL_D3:    state_nxt = DONE;
      DONE:       state_nxt = DONE;
      default:    state_nxt = DEAL_P1;
    endcase
  end

  always_comb begin
    load_pcard1      = 1'b0;
    load_pcard2      = 1'b0;
    load_pcard3      = 1'b0;
    load_dcard1      = 1'b0;
    load_dcard2      = 1'b0;
    load_dcard3      = 1'b0;
    player_win_light = 1'b0;
    dealer_win_light = 1'b0;
    done             = 1'b0;
    case (state)
      DEAL_P1: load_pcard1 = 1'b1;
      DEAL_D1: load_dcard1 = 1'b1;
      DEAL_P2: load_pcard2 = 1'b1;
      DEAL_D2: load_dcard2 = 1'b1;
      DEAL_P3: load_pcard3 = 1'b1;
      DEAL_D3: load_dcard3 = 1'b1;
      DONE: begin
        done             = 1'b1;
        player_win_light = (pscore >= dscore);
        dealer_win_light = (dscore >= pscore);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_baccarat_deal_fsm.sv
// Directed bench for baccarat_deal_fsm: walks hands state by state and checks
// strobes, done and lamps against hand-computed vectors.
module tb_baccarat_deal_fsm;

  logic       slow_clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] pscore = 4'd0, dscore = 4'd0, pcard3 = 4'd0;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light, done;

  int vectors = 0;
  int miscompares = 0;

  baccarat_deal_fsm dut (
    .slow_clock(slow_clock), .reset(reset),
    .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
    .load_pcard1(load_pcard1), .load_pcard2(load_pcard2), .load_pcard3(load_pcard3),
    .load_dcard1(load_dcard1), .load_dcard2(load_dcard2), .load_dcard3(load_dcard3),
    .player_win_light(player_win_light), .dealer_win_light(dealer_win_light),
    .done(done)
  );

  always #5 slow_clock = ~slow_clock;

  // {lp1, ld1, lp2, ld2, lp3, ld3, pwin, dwin, done}
  logic [8:0] outs;
  assign outs = {load_pcard1, load_dcard1, load_pcard2, load_dcard2,
                 load_pcard3, load_dcard3, player_win_light, dealer_win_light, done};

  localparam logic [8:0] O_P1 = 9'h100, O_D1 = 9'h080, O_P2 = 9'h040, O_D2 = 9'h020;
  localparam logic [8:0] O_P3 = 9'h010, O_D3 = 9'h008, O_IDLE = 9'h000;
  localparam logic [8:0] O_PWIN = 9'h005, O_DWIN = 9'h003, O_TIE = 9'h007;

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [8:0] exp);
    @(posedge slow_clock);
    #1;
    chk(tag, outs, exp);
    chk({tag, "_strobe_onehot"}, 9'($countones(outs[8:3]) <= 1), 9'd1);
  endtask

  function automatic logic [8:0] lamps(input logic [3:0] ps, input logic [3:0] ds);
    if (ps > ds)      return O_PWIN;
    else if (ds > ps) return O_DWIN;
    else              return O_TIE;
  endfunction

  // Reset, then run the four unconditional deals up to CHECK_NAT.
  task automatic deal4(input string tag);
    @(negedge slow_clock);
    reset = 1'b1;
    #1;
    chk({tag, "_rst"}, outs, O_P1);
    reset = 1'b0;
    #1;
    chk({tag, "_p1_pre"}, outs, O_P1);
    step({tag, "_d1"}, O_D1);
    step({tag, "_p2"}, O_P2);
    step({tag, "_d2"}, O_D2);
    step({tag, "_chk"}, O_IDLE);
  endtask

  // {dscore, pcard3, banker draws?}
  int bank_tab[10][3] = '{
    '{3, 8, 0}, '{3, 12, 1}, '{3, 14, 1}, '{4, 1, 0}, '{4, 7, 1},
    '{4, 10, 0}, '{5, 4, 1}, '{5, 3, 0}, '{6, 7, 1}, '{7, 6, 0}
  };

  initial begin
    #2;
    chk("init_rst", outs, O_P1);

    // Natural: player 8 vs banker 3.
    pscore = 4'd8; dscore = 4'd3;
    deal4("nat");
    step("nat_done", O_PWIN);
    step("nat_absorb", O_PWIN);
    dscore = 4'd9; #1;
    chk("nat_dwin", outs, O_DWIN);
    pscore = 4'd9; #1;
    chk("nat_tie", outs, O_TIE);

    // Banker natural with player 0.
    pscore = 4'd0; dscore = 4'd9;
    deal4("bnat");
    step("bnat_done", O_DWIN);

    // Player draws (5), banker 6 stands on v=9; player ends on 4.
    pscore = 4'd5; dscore = 4'd6; pcard3 = 4'd9;
    deal4("pdraw");
    step("pdraw_p3", O_P3);
    pscore = 4'd4;
    step("pdraw_cb", O_IDLE);
    step("pdraw_done", O_DWIN);

    // Player stands on 7, banker 4 draws directly; both finish on 7.
    pscore = 4'd7; dscore = 4'd4;
    deal4("bdraw");
    step("bdraw_d3", O_D3);
    dscore = 4'd7;
    step("bdraw_done", O_TIE);
    step("bdraw_absorb", O_TIE);

    // Both stand on 6.
    pscore = 4'd6; dscore = 4'd6;
    deal4("stand");
    step("stand_done", O_TIE);

    // Banker third-card rule, player always on 2 so it draws first.
    foreach (bank_tab[i]) begin
      pscore = 4'd2; dscore = 4'(bank_tab[i][0]); pcard3 = 4'(bank_tab[i][1]);
      deal4($sformatf("bank%0d", i));
      step($sformatf("bank%0d_p3", i), O_P3);
      step($sformatf("bank%0d_cb", i), O_IDLE);
      if (bank_tab[i][2] != 0)
        step($sformatf("bank%0d_d3", i), O_D3);
      step($sformatf("bank%0d_done", i), lamps(4'd2, 4'(bank_tab[i][0])));
    end

    // Reset mid-hand while in DEAL_P3, with no clock edge.
    pscore = 4'd2; dscore = 4'd3; pcard3 = 4'd12;
    deal4("mid");
    step("mid_p3", O_P3);
    reset = 1'b1;
    #1;
    chk("mid_rst", outs, O_P1);
    @(negedge slow_clock);
    reset = 1'b0;
    #1;
    chk("mid_p1_pre", outs, O_P1);
    step("mid_d1", O_D1);
    step("mid_p2", O_P2);
    step("mid_d2", O_D2);
    step("mid_chk", O_IDLE);
    step("mid_p3b", O_P3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
